// File: rtl/serial_link_isolate_ctrl.sv
// Serial-link power sequencer: ordered clock/reset/isolation bring-up and tear-down
// with a timeout on each isolation handshake and a sticky error flag.
module serial_link_isolate_ctrl #(
  parameter int ResetCycles   = 8,
  parameter int SettleCycles  = 4,
  parameter int TimeoutCycles = 1024,
  parameter int CntWidth      = $clog2(
    (((ResetCycles > SettleCycles) ? ResetCycles : SettleCycles) > TimeoutCycles
       ? ((ResetCycles > SettleCycles) ? ResetCycles : SettleCycles)
       : TimeoutCycles) + 1)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] isolated_i,
  input  logic       err_clr_i,
  output logic [1:0] isolate_o,
  output logic       clk_ena_o,
  output logic       reset_no,
  output logic       busy_o,
  output logic       on_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    S_OFF, S_CLK_ON, S_RST_REL, S_DEISO, S_ON, S_ISO, S_RST_ASSERT
  } state_e;

  localparam logic [CntWidth-1:0] RstLast = CntWidth'(ResetCycles - 1);
  localparam logic [CntWidth-1:0] SetLast = CntWidth'(SettleCycles - 1);
  localparam logic [CntWidth-1:0] ToLast  = CntWidth'(TimeoutCycles - 1);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                set_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Handshakes need both stage acknowledges to agree; a split ack just waits.
  always_comb begin
    state_d = state_q;
    set_err = 1'b0;
    case (state_q)
      S_OFF:        if (en_i) state_d = S_CLK_ON;
      S_CLK_ON:     if (cnt_q == RstLast) state_d = S_RST_REL;
      S_RST_REL:    if (cnt_q == SetLast) state_d = S_DEISO;
      S_DEISO: begin
        if (isolated_i == 2'b00) begin
          state_d = S_ON;
        end else if (cnt_q == ToLast) begin
          state_d = S_ISO;
          set_err = 1'b1;
        end
      end
      S_ON:         if (!en_i) state_d = S_ISO;
      S_ISO: begin
        if (isolated_i == 2'b11) begin
          state_d = S_RST_ASSERT;
        end else if (cnt_q == ToLast) begin
          state_d = S_RST_ASSERT;
          set_err = 1'b1;
        end
      end
      S_RST_ASSERT: if (cnt_q == RstLast) state_d = S_OFF;
      default:      state_d = S_OFF;
    endcase
  end

  always_comb begin
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_q != '1)   cnt_d = cnt_q + 1'b1;
    else                    cnt_d = cnt_q;
  end

  always_comb begin
    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (set_err)   err_d = 1'b1;
  end

  // Outputs decode straight from the state register, so nothing is combinational from inputs.
  always_comb begin
    isolate_o = 2'b11;
    clk_ena_o = 1'b1;
    reset_no  = 1'b0;
    case (state_q)
      S_OFF:        clk_ena_o = 1'b0;
      S_CLK_ON:     reset_no  = 1'b0;
      S_RST_REL:    reset_no  = 1'b1;
      S_DEISO: begin
        isolate_o = 2'b00;
        reset_no  = 1'b1;
      end
      S_ON: begin
        isolate_o = 2'b00;
        reset_no  = 1'b1;
      end
      S_ISO:        reset_no  = 1'b1;
      S_RST_ASSERT: reset_no  = 1'b0;
      default:      clk_ena_o = 1'b0;
    endcase
  end

  assign busy_o = (state_q != S_OFF) && (state_q != S_ON);
  assign on_o   = (state_q == S_ON);
  assign err_o  = err_q;

endmodule

// File: tb/tb_serial_link_isolate_ctrl.sv
// Bench for serial_link_isolate_ctrl: randomized ack lags and hold times, expected
// output timelines computed arithmetically from the sequencing rules.
module tb_serial_link_isolate_ctrl;
  localparam int R = 8;
  localparam int S = 4;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst, en, err_clr;
  logic [1:0] isolated;
  logic [1:0] iso;
  logic       clk_ena, rstn, busy, on, err;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] hist [0:7];
  int         lag;
  bit         frc;
  logic [1:0] frc_val;
  logic       exp_err;

  always #5 clk = ~clk;

  serial_link_isolate_ctrl #(
    .ResetCycles(R), .SettleCycles(S), .TimeoutCycles(T)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .isolated_i(isolated), .err_clr_i(err_clr),
    .isolate_o(iso), .clk_ena_o(clk_ena), .reset_no(rstn),
    .busy_o(busy), .on_o(on), .err_o(err)
  );

  function automatic logic [6:0] ev(logic [1:0] i, logic c, logic r, logic b, logic o, logic e);
    return {i, c, r, b, o, e};
  endfunction

  task automatic chk(input string tag, input int n, input logic [6:0] exp);
    logic [6:0] got;
    got = {iso, clk_ena, rstn, busy, on, err};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s n=%0d got iso/clk/rstn/busy/on/err=%b expected %b", tag, n, got, exp);
    end
  endtask

  // Ack responder: isolated mirrors isolate_o with a lag-edge delay unless forced.
  task automatic drive_ack();
    isolated = frc ? frc_val : hist[lag-1];
  endtask

  task automatic tick();
    logic [1:0] bad;
    @(posedge clk);
    #1;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = iso;
    drive_ack();
    bad = {rstn & ~clk_ena, (iso == 2'b00) & ~rstn};
    checks++;
    assert (bad === 2'b00) else begin
      errors++;
      $error("FAIL ordering got %b expected 00", bad);
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      tick();
      chk("idle_off", i, ev(2'b11, 0, 0, 0, 0, exp_err));
    end
  endtask

  task automatic bringup(input int glitch_at);
    en = 1'b1;
    for (int n = 0; n <= R + S + lag; n++) begin
      tick();
      if (n < R)              chk("bringup", n, ev(2'b11, 1, 0, 1, 0, exp_err));
      else if (n < R + S)     chk("bringup", n, ev(2'b11, 1, 1, 1, 0, exp_err));
      else if (n < R + S + lag) chk("bringup", n, ev(2'b00, 1, 1, 1, 0, exp_err));
      else                    chk("bringup", n, ev(2'b00, 1, 1, 0, 1, exp_err));
      if (n == glitch_at) en = 1'b0;
    end
  endtask

  task automatic teardown();
    en = 1'b0;
    for (int n = 0; n <= lag + R; n++) begin
      tick();
      if (n < lag)          chk("teardown", n, ev(2'b11, 1, 1, 1, 0, exp_err));
      else if (n < lag + R) chk("teardown", n, ev(2'b11, 1, 0, 1, 0, exp_err));
      else                  chk("teardown", n, ev(2'b11, 0, 0, 0, 0, exp_err));
    end
  endtask

  task automatic bringup_partial(input int p);
    frc = 1'b1;
    frc_val = $urandom_range(0, 1) ? 2'b01 : 2'b10;
    drive_ack();
    en = 1'b1;
    for (int n = 0; n <= R + S + p + 1; n++) begin
      tick();
      if (n < R)                chk("partial", n, ev(2'b11, 1, 0, 1, 0, exp_err));
      else if (n < R + S)       chk("partial", n, ev(2'b11, 1, 1, 1, 0, exp_err));
      else if (n <= R + S + p)  chk("partial", n, ev(2'b00, 1, 1, 1, 0, exp_err));
      else                      chk("partial", n, ev(2'b00, 1, 1, 0, 1, exp_err));
      if (n == R + S + p) begin
        frc_val = 2'b00;
        drive_ack();
      end
    end
    frc = 1'b0;
    drive_ack();
  endtask

  task automatic teardown_timeout();
    logic e0;
    e0 = exp_err;
    frc = 1'b1;
    frc_val = 2'b00;
    drive_ack();
    en = 1'b0;
    for (int n = 0; n <= T + R; n++) begin
      tick();
      if (n < T)          chk("iso_to", n, ev(2'b11, 1, 1, 1, 0, e0));
      else if (n < T + R) chk("iso_to", n, ev(2'b11, 1, 0, 1, 0, 1));
      else                chk("iso_to", n, ev(2'b11, 0, 0, 0, 0, 1));
    end
    exp_err = 1'b1;
    frc = 1'b0;
    drive_ack();
  endtask

  // DEISO never sees a full ack, then ISO never does either: two timeouts back to OFF.
  // err_clr is pulsed on the first timeout edge, where setting must win.
  task automatic deiso_timeout();
    logic e0;
    int   t1, t2;
    e0 = exp_err;
    t1 = R + S + T;
    t2 = t1 + T;
    frc = 1'b1;
    frc_val = $urandom_range(0, 1) ? 2'b01 : 2'b10;
    drive_ack();
    en = 1'b1;
    for (int n = 0; n <= t2 + R; n++) begin
      tick();
      if (n == 0) en = 1'b0;
      if (n < R)           chk("deiso_to", n, ev(2'b11, 1, 0, 1, 0, e0));
      else if (n < R + S)  chk("deiso_to", n, ev(2'b11, 1, 1, 1, 0, e0));
      else if (n < t1)     chk("deiso_to", n, ev(2'b00, 1, 1, 1, 0, e0));
      else if (n < t2)     chk("deiso_to", n, ev(2'b11, 1, 1, 1, 0, 1));
      else if (n < t2 + R) chk("deiso_to", n, ev(2'b11, 1, 0, 1, 0, 1));
      else                 chk("deiso_to", n, ev(2'b11, 0, 0, 0, 0, 1));
      err_clr = (n == t1 - 1);
    end
    exp_err = 1'b1;
    frc = 1'b0;
    drive_ack();
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err = 1'b0;
    chk("err_clr", 0, ev(2'b11, 0, 0, 0, 0, 0));
    tick();
    chk("err_clr", 1, ev(2'b11, 0, 0, 0, 0, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; err_clr = 1'b0; isolated = 2'b11;
    frc = 1'b0; frc_val = 2'b11; lag = 1; exp_err = 1'b0;
    for (int i = 0; i < 8; i++) hist[i] = 2'b11;
    #12;
    chk("reset", 0, ev(2'b11, 0, 0, 0, 0, 0));
    tick();
    #2 rst = 1'b0;
    idle($urandom_range(1, 3));

    for (int it = 0; it < 3; it++) begin
      lag = $urandom_range(1, 4);
      bringup(-1);
      idle(0);
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
        tick();
        chk("hold_on", i, ev(2'b00, 1, 1, 0, 1, 0));
      end
      lag = $urandom_range(1, 4);
      teardown();
      idle($urandom_range(1, 3));
    end

    lag = $urandom_range(1, 4);
    bringup(int'($urandom_range(R, R + S - 1)));
    teardown();
    idle(2);

    lag = $urandom_range(1, 4);
    bringup_partial(int'($urandom_range(4, T - 3)));
    teardown();
    idle(1);

    lag = $urandom_range(1, 4);
    bringup(-1);
    teardown_timeout();
    idle(3);
    clear_err();

    deiso_timeout();
    idle(2);

    lag = $urandom_range(1, 4);
    bringup(-1);
    #2 rst = 1'b1;
    #1 chk("async_rst", 0, ev(2'b11, 0, 0, 0, 0, 0));
    exp_err = 1'b0;
    for (int i = 0; i < 8; i++) hist[i] = 2'b11;
    drive_ack();
    tick();
    chk("in_rst", 0, ev(2'b11, 0, 0, 0, 0, 0));
    #2 rst = 1'b0;
    en = 1'b0;
    idle(2);

    lag = $urandom_range(1, 4);
    bringup(-1);
    teardown();
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
